// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Steps a one-hot phase vector through NUM_PHASES phases per round. One
// operation runs a programmable number of rounds. Other features:
//   - restart on begin_op
//   - stall
//   - free-running rotation while idle
//   - self-repair of a corrupted (non one-hot) phase vector
// The wrap/done pulses drive the operand and accumulator control logic.
//
// Parameters
//   NUM_PHASES : phases per round (2..32)
//   ITER_W     : width of the round counter and of the iterations input
//   PH_W       : derived, width of phase_idx
//
// Ports
//   clk        in   single clock; all state updates on the rising edge
//   reset      in   synchronous, active-high
//   begin_op   in   start or restart an operation
//   iterations in   number of rounds, sampled only when begin_op is accepted
//   stall      in   hold all state for this edge
//   free_run   in   continuous rotation while no operation is in progress
//   state      out  one-hot phase vector (registered)
//   phase_idx  out  binary index of the set bit of state (combinational)
//   round      out  current 0-based round number (registered)
//   busy       out  operation in progress (registered)
//   wrap       out  pulse after each last-phase -> phase 0 step
//   done       out  pulse after the final phase of the final round
//   err        out  pulse after an illegal state was repaired
// -----------------------------------------------------------------------------
module phase_sequencer #(
  parameter  int NUM_PHASES = 4,
  parameter  int ITER_W     = 4,
  localparam int PH_W       = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  begin_op,
  input  logic [ITER_W-1:0]     iterations,
  input  logic                  stall,
  input  logic                  free_run,
  output logic [NUM_PHASES-1:0] state,
  output logic [PH_W-1:0]       phase_idx,
  output logic [ITER_W-1:0]     round,
  output logic                  busy,
  output logic                  wrap,
  output logic                  done,
  output logic                  err
);

  typedef enum logic {
    MODE_IDLE = 1'b0,
    MODE_RUN  = 1'b1
  } mode_e;

  localparam logic [NUM_PHASES-1:0] PHASE0 = NUM_PHASES'(1);

  mode_e                 mode_q,   mode_d;
  logic [NUM_PHASES-1:0] state_q,  state_d;
  logic [ITER_W-1:0]     round_q,  round_d;
  logic [ITER_W-1:0]     target_q, target_d;
  logic                  wrap_q,   wrap_d;
  logic                  done_q,   done_d;
  logic                  err_q,    err_d;

  logic                  state_legal;
  logic [NUM_PHASES-1:0] state_rot;
  logic                  at_last_phase;
  logic                  at_last_round;

  // One-hot test: non-zero, and clearing the lowest set bit leaves nothing.
  assign state_legal   = (state_q != '0) &&
                         ((state_q & (state_q - NUM_PHASES'(1))) == '0);
  assign state_rot     = {state_q[NUM_PHASES-2:0], state_q[NUM_PHASES-1]};
  assign at_last_phase = state_q[NUM_PHASES-1];
  // Only consulted while running, where target is at least 1.
  assign at_last_round = (round_q == (target_q - ITER_W'(1)));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_IDLE;
      state_q  <= PHASE0;
      round_q  <= '0;
      target_q <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      state_q  <= state_d;
      round_q  <= round_d;
      target_q <= target_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // Priority: repair > begin_op > stall > advance / free-run / idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_d   = mode_q;
    state_d  = state_q;
    round_d  = round_q;
    target_d = target_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (!state_legal) begin
      // A corrupted phase vector aborts everything.
      // A simultaneous begin_op is dropped.
      state_d = PHASE0;
      round_d = '0;
      mode_d  = MODE_IDLE;
      err_d   = 1'b1;
    end else if (begin_op) begin
      // Abandons any operation in flight; no done for the old one.
      state_d  = PHASE0;
      round_d  = '0;
      target_d = iterations;
      if (iterations != '0) begin
        mode_d = MODE_RUN;
      end else begin
        mode_d = MODE_IDLE;
        done_d = 1'b1;
      end
    end else if (stall) begin
      // Everything holds; pulses stay low.
    end else if (mode_q == MODE_RUN) begin
      state_d = state_rot;
      if (at_last_phase) begin
        wrap_d = 1'b1;
        if (at_last_round) begin
          round_d = '0;
          mode_d  = MODE_IDLE;
          done_d  = 1'b1;
        end else begin
          round_d = round_q + ITER_W'(1);
        end
      end
    end else if (free_run) begin
      // Uncounted ring: round wraps naturally modulo 2^ITER_W.
      state_d = state_rot;
      if (at_last_phase) begin
        wrap_d  = 1'b1;
        round_d = round_q + ITER_W'(1);
      end
    end else begin
      // Idle without free-run parks at phase 0 / round 0.
      // This also recovers the position left behind when free_run drops.
      state_d = PHASE0;
      round_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Binary encode of the phase vector.
  // Because the vector is one-hot, OR-ing the indices of the set bits gives the
  // index directly. A corrupted vector reports 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_idx = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (state_q[i]) begin
        phase_idx = phase_idx | PH_W'(i);
      end
    end
    if (!state_legal) begin
      phase_idx = '0;
    end
  end

  assign state = state_q;
  assign round = round_q;
  assign busy  = (mode_q == MODE_RUN);
  assign wrap  = wrap_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
